udiv64_seq: RTL
===============

Name: udiv64_seq

Overview:
- Sequential radix-2 restoring unsigned divider. It is the inverse-operation partner of the team's 64-bit combinational unsigned multiplier.
- Accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock.
- Returns the quotient and remainder with a one-cycle done pulse.
- Sits beside the multiplier in the arithmetic unit and shares its operand width. Intended for area-constrained paths where a combinational divider is unaffordable.

Parameters:
- WIDTH, 64, operand/result width in bits (must be >= 2).
- CNT_W, 7, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when not busy.
- dividend  input  WIDTH  unsigned numerator, sampled on accepted start.
- divisor  input  WIDTH  unsigned denominator, sampled on accepted start.
- busy  output  1  high while iterating; start ignored.
- done  output  1  one-cycle pulse when results are updated.
- quotient  output  WIDTH  registered quotient, stable between done pulses.
- remainder  output  WIDTH  registered remainder, stable between done pulses.
- div_by_zero  output  1  registered flag; valid with done, held until next done.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, internal working regs=0. Reset mid-iteration aborts the operation with no done pulse.
- States:
  - IDLE: waiting.
  - RUN: iterating.
  - DONE: one cycle, done=1.
- Start is accepted when state is IDLE or DONE and start=1 at a rising edge.
  - Accepted start with divisor!=0: latch dividend into the quotient-shift reg Q, divisor into D, partial remainder R (WIDTH+1 bits) = 0, counter = WIDTH, then go to RUN with busy=1.
  - Accepted start with divisor==0: go directly to DONE. Load quotient = all ones, remainder = dividend, div_by_zero = 1.
- RUN, each cycle:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} (WIDTH+1 bits).
  - If T >= {1'b0, D}: R = T - D and shift 1 into Q LSB.
  - Else: R = T and shift 0 into Q LSB.
  - Decrement counter. When the counter reaches 1 in this cycle, go to DONE on the next edge.
- Entering DONE from RUN: quotient <= final Q, remainder <= final R[WIDTH-1:0], div_by_zero <= 0. In DONE, done=1 and busy=0.
- DONE returns to IDLE unless a new start is accepted in the same cycle. Back-to-back operation is allowed, and done then pulses for exactly one cycle.
- Latency, with start accepted at edge k:
  - Nonzero divisor: done is high in the cycle after edge k+WIDTH (64 cycles for the default).
  - Zero divisor: done is high in the cycle after edge k.
  - Latency is data-independent, with no early termination.
- start while busy=1 is ignored, and its operands are not sampled. Operand changes during RUN have no effect.
- quotient, remainder and div_by_zero change only on the DONE-entry edge or on reset. They hold the previous result throughout RUN.
- Invariants for divisor!=0: dividend == quotient*divisor + remainder, and remainder < divisor.
- busy and done are never high simultaneously.

Test Plan:
- Basic: dividend=100, divisor=7, start one cycle -> busy high for 64 cycles, then done=1 for exactly one cycle, quotient=14, remainder=2, div_by_zero=0.
- Extremes: dividend=64'hFFFF_FFFF_FFFF_FFFF, divisor=1 -> quotient=all ones, remainder=0. Then dividend=5, divisor=64'hFFFF_FFFF_FFFF_FFFF -> quotient=0, remainder=5.
- Divide by zero: dividend=1234, divisor=0 -> done one cycle after start, quotient=all ones, remainder=1234, div_by_zero=1, busy never asserted.
- Handshake:
  - start pulsed again mid-RUN with dividend=9, divisor=3 -> ignored; the first operation's result is delivered unchanged.
  - start held high during the DONE cycle -> new operation is accepted and done is a single-cycle pulse.
- Reset mid-operation: rst_n pulsed low at cycle 30 of RUN -> immediately busy=0, done=0, quotient=0, remainder=0; no done pulse follows. A subsequent 81/9 then returns quotient=9, remainder=0.
- Random: 10k random operand pairs, including divisor > dividend -> every result satisfies the invariants and matches the reference-model quotient and remainder.

Source files
------------

// File: rtl/udiv64_seq.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock.
// Latency: WIDTH+1 cycles from accepted start to done for a nonzero divisor, 1 cycle for a zero divisor.
// Backpressure: none; start is ignored while busy, and results are held until the next done.
module udiv64_seq #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_reg, d_reg;
  logic [WIDTH:0]   r_reg;
  logic [CNT_W-1:0] cnt;

  logic             accept, div_zero_in, last;
  logic [WIDTH:0]   t, r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             ge;

  // A new request can land in IDLE or in the DONE cycle (back-to-back operation).
  assign accept      = start && (state != RUN);
  assign div_zero_in = (divisor == '0);
  // Final iteration: the step computed this cycle is the result.
  assign last        = (state == RUN) && (cnt == CNT_W'(1));

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    t     = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    ge    = (t >= {1'b0, d_reg});
    r_nxt = ge ? (t - {1'b0, d_reg}) : t;
    q_nxt = {q_reg[WIDTH-2:0], ge};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs; busy and done are decoded from distinct states so they never overlap.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = div_zero_in ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = div_zero_in ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers: load operands on a nonzero-divisor start, otherwise iterate while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
      d_reg <= '0;
      r_reg <= '0;
      cnt   <= '0;
    end else if (accept && !div_zero_in) begin
      q_reg <= dividend;
      d_reg <= divisor;
      r_reg <= '0;
      cnt   <= CNT_W'(WIDTH);
    end else if (state == RUN) begin
      q_reg <= q_nxt;
      r_reg <= r_nxt;
      cnt   <= cnt - CNT_W'(1);
    end
  end

  // Result registers change only when entering DONE, so they hold the previous result through RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && div_zero_in) begin
      quotient    <= '1;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (last) begin
      quotient    <= q_nxt;
      remainder   <= r_nxt[WIDTH-1:0];
      div_by_zero <= 1'b0;
    end
  end

endmodule
